hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding unit for the pipelined MIPS core. A shift register of
// in-flight destination records, one slot per stage after ID, replaces fixed
// EX/MEM and MEM/WB comparators. Slot 0 is EX and slot DEPTH-1 is WB.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge) and asynchronous active-low reset
//   i_id_valid            ID holds a real instruction
//   i_id_rs, i_id_rt      source registers of the ID instruction
//   i_id_use_rs/_rt       the operand is actually read
//   i_id_wr_en, i_id_rd   the ID instruction writes register i_id_rd
//   i_id_is_load          the ID instruction is a load
//   i_id_branch_taken     branch resolved taken in ID
//   o_stall               combinational load-use interlock request
//   o_pc_write            PC enable (= ~stall)
//   o_if_id_write         IF/ID enable (= ~stall)
//   o_if_flush            flush IF on a taken branch that is actually issuing
//   o_issue               ID instruction moves into EX this cycle
//   o_fwd_a, o_fwd_b      registered forward selects for the instruction in EX
//                         (0 = register file, k = result of stage k)
//   o_stall_count         saturating count of stall cycles
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   localparam int FW      = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_use_rs,
   input  logic              i_id_use_rt,
   input  logic              i_id_wr_en,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic              i_id_is_load,
   input  logic              i_id_branch_taken,
   output logic              o_stall,
   output logic              o_pc_write,
   output logic              o_if_id_write,
   output logic              o_if_flush,
   output logic              o_issue,
   output logic [FW-1:0]     o_fwd_a,
   output logic [FW-1:0]     o_fwd_b,
   output logic [15:0]       o_stall_count
);

   typedef struct packed {
      logic              v;
      logic              wr;
      logic [REG_AW-1:0] rd;
      logic              ld;
   } slot_t;

   slot_t             r_slot [DEPTH];
   logic [FW-1:0]     r_fwd_a;
   logic [FW-1:0]     r_fwd_b;
   logic [15:0]       r_stall_count;

   logic [FW-1:0]     w_sel_a;
   logic [FW-1:0]     w_sel_b;
   logic              w_late_a;
   logic              w_late_b;
   logic              w_stall;
   logic              w_issue;

   // Searches the matchable slots from oldest to youngest so the youngest
   // producer overwrites any older one. The WB slot is excluded because the
   // register file is write-first. Returns {late, select}.
   function automatic logic [FW:0] lookup(input logic use_x,
                                          input logic [REG_AW-1:0] reg_x);
      logic [FW-1:0] sel;
      logic          late;
      sel  = '0;
      late = 1'b0;
      for (int j = DEPTH - 2; j >= 0; j--) begin
         if (use_x && r_slot[j].v && r_slot[j].wr &&
             (r_slot[j].rd == reg_x) && (reg_x != '0)) begin
            sel  = FW'(j + 1);
            late = r_slot[j].ld && ((j + 1) < (1 + LOAD_LAT));
         end
      end
      return {late, sel};
   endfunction

   always_comb begin
      {w_late_a, w_sel_a} = lookup(i_id_use_rs, i_id_rs);
      {w_late_b, w_sel_b} = lookup(i_id_use_rt, i_id_rt);
   end

   // A taken branch held by an interlock must not flush yet; it flushes when
   // it finally issues.
   assign w_stall       = i_id_valid & (w_late_a | w_late_b);
   assign w_issue       = i_id_valid & ~w_stall;
   assign o_stall       = w_stall;
   assign o_pc_write    = ~w_stall;
   assign o_if_id_write = ~w_stall;
   assign o_if_flush    = i_id_branch_taken & i_id_valid & ~w_stall;
   assign o_issue       = w_issue;
   assign o_fwd_a       = r_fwd_a;
   assign o_fwd_b       = r_fwd_b;
   assign o_stall_count = r_stall_count;

   // A stalled ID instruction leaves a bubble in EX while the older records
   // keep advancing toward WB.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int j = 0; j < DEPTH; j++) begin
            r_slot[j] <= '0;
         end
         r_fwd_a       <= '0;
         r_fwd_b       <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_issue) begin
            r_slot[0] <= '{v: 1'b1, wr: i_id_wr_en, rd: i_id_rd, ld: i_id_is_load};
            r_fwd_a   <= w_sel_a;
            r_fwd_b   <= w_sel_b;
         end else begin
            r_slot[0] <= '0;
            r_fwd_a   <= '0;
            r_fwd_b   <= '0;
         end
         for (int j = 1; j < DEPTH; j++) begin
            r_slot[j] <= r_slot[j-1];
         end
         if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. Two instances share the ID-stage inputs:
// d0 uses default parameters (DEPTH=3, LOAD_LAT=1), d1 uses DEPTH=4,
// LOAD_LAT=2. Each scenario drives directed instruction sequences and compares
// against hand-computed values.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rstN;
   logic       idValid;
   logic [4:0] idRs;
   logic [4:0] idRt;
   logic       idUseRs;
   logic       idUseRt;
   logic       idWrEn;
   logic [4:0] idRd;
   logic       idIsLoad;
   logic       idBranchTaken;

   logic        d0Stall, d0PcWrite, d0IfIdWrite, d0IfFlush, d0Issue;
   logic [1:0]  d0FwdA, d0FwdB;
   logic [15:0] d0StallCount;
   logic        d1Stall, d1PcWrite, d1IfIdWrite, d1IfFlush, d1Issue;
   logic [1:0]  d1FwdA, d1FwdB;
   logic [15:0] d1StallCount;

   int checkCount;
   int errorCount;

   hazard_scoreboard d0 (
      .i_clk(clk), .i_rst_n(rstN), .i_id_valid(idValid),
      .i_id_rs(idRs), .i_id_rt(idRt), .i_id_use_rs(idUseRs), .i_id_use_rt(idUseRt),
      .i_id_wr_en(idWrEn), .i_id_rd(idRd), .i_id_is_load(idIsLoad),
      .i_id_branch_taken(idBranchTaken),
      .o_stall(d0Stall), .o_pc_write(d0PcWrite), .o_if_id_write(d0IfIdWrite),
      .o_if_flush(d0IfFlush), .o_issue(d0Issue), .o_fwd_a(d0FwdA), .o_fwd_b(d0FwdB),
      .o_stall_count(d0StallCount)
   );

   hazard_scoreboard #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2)) d1 (
      .i_clk(clk), .i_rst_n(rstN), .i_id_valid(idValid),
      .i_id_rs(idRs), .i_id_rt(idRt), .i_id_use_rs(idUseRs), .i_id_use_rt(idUseRt),
      .i_id_wr_en(idWrEn), .i_id_rd(idRd), .i_id_is_load(idIsLoad),
      .i_id_branch_taken(idBranchTaken),
      .o_stall(d1Stall), .o_pc_write(d1PcWrite), .o_if_id_write(d1IfIdWrite),
      .o_if_flush(d1IfFlush), .o_issue(d1Issue), .o_fwd_a(d1FwdA), .o_fwd_b(d1FwdB),
      .o_stall_count(d1StallCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Presents one ID-stage instruction right after a falling edge so that it
   // is settled well before the next rising edge; outputs are sampled 1ns later.
   task automatic applyStimulus(input logic valid, input logic [4:0] rs,
                                input logic [4:0] rt, input logic useRs,
                                input logic useRt, input logic wrEn,
                                input logic [4:0] rd, input logic isLoad,
                                input logic br);
      @(negedge clk);
      idValid       = valid;
      idRs          = rs;
      idRt          = rt;
      idUseRs       = useRs;
      idUseRt       = useRt;
      idWrEn        = wrEn;
      idRd          = rd;
      idIsLoad      = isLoad;
      idBranchTaken = br;
      #1;
   endtask

   task automatic applyNop();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Holds reset across a rising edge, then releases it with ID idle.
   task automatic resetDut();
      @(negedge clk);
      rstN = 1'b0;
      applyNop();
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      checkCount    = 0;
      errorCount    = 0;
      rstN          = 1'b1;
      idValid       = 1'b0;
      idRs          = '0;
      idRt          = '0;
      idUseRs       = 1'b0;
      idUseRt       = 1'b0;
      idWrEn        = 1'b0;
      idRd          = '0;
      idIsLoad      = 1'b0;
      idBranchTaken = 1'b0;

      // Reset state, with a taken branch presented during reset.
      #2 rstN = 1'b0;
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
      @(negedge clk); #1;
      checkOutput("rst_stall", d0Stall, 0);
      checkOutput("rst_pc_write", d0PcWrite, 1);
      checkOutput("rst_if_id_write", d0IfIdWrite, 1);
      checkOutput("rst_if_flush", d0IfFlush, 1);
      checkOutput("rst_issue", d0Issue, 1);
      checkOutput("rst_fwd_a", d0FwdA, 0);
      checkOutput("rst_fwd_b", d0FwdB, 0);
      checkOutput("rst_stall_count", d0StallCount, 0);
      resetDut();

      // ALU back-to-back: add r3 then sub reading rs=r3.
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      checkOutput("alu_prod_issue", d0Issue, 1);
      applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      checkOutput("alu_cons_stall", d0Stall, 0);
      applyNop();
      checkOutput("alu_fwd_a", d0FwdA, 1);
      checkOutput("alu_fwd_b", d0FwdB, 0);

      // Load-use with default parameters: lw r5 then add reading rt=r5.
      resetDut();
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      checkOutput("lu_stall", d0Stall, 1);
      checkOutput("lu_pc_write", d0PcWrite, 0);
      checkOutput("lu_issue", d0Issue, 0);
      applyStimulus(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      checkOutput("lu_stall_released", d0Stall, 0);
      checkOutput("lu_issue_after", d0Issue, 1);
      checkOutput("lu_bubble_fwd_b", d0FwdB, 0);
      applyNop();
      checkOutput("lu_fwd_b", d0FwdB, 2);
      checkOutput("lu_fwd_a", d0FwdA, 0);
      checkOutput("lu_stall_count", d0StallCount, 1);

      // DEPTH=4, LOAD_LAT=2: consumer directly after lw r7.
      resetDut();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
      checkOutput("deep_stall_1", d1Stall, 1);
      applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
      checkOutput("deep_stall_2", d1Stall, 1);
      applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
      checkOutput("deep_stall_3", d1Stall, 0);
      applyNop();
      checkOutput("deep_fwd_a", d1FwdA, 3);
      checkOutput("deep_stall_count", d1StallCount, 2);

      // Same, with one independent instruction in between.
      resetDut();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
      checkOutput("gap_indep_stall", d1Stall, 0);
      applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
      checkOutput("gap_stall_1", d1Stall, 1);
      applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
      checkOutput("gap_stall_2", d1Stall, 0);
      applyNop();
      checkOutput("gap_fwd_a", d1FwdA, 3);
      checkOutput("gap_stall_count", d1StallCount, 1);

      // A load targeting r0 never creates a hazard or a forward.
      resetDut();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
      checkOutput("r0_stall", d0Stall, 0);
      applyNop();
      checkOutput("r0_fwd_a", d0FwdA, 0);
      checkOutput("r0_fwd_b", d0FwdB, 0);

      // ALU and load both write r4; the younger load governs.
      resetDut();
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
      checkOutput("dup_load_stall", d0Stall, 0);
      applyStimulus(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0);
      checkOutput("dup_cons_stall", d0Stall, 1);
      applyStimulus(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0);
      checkOutput("dup_cons_release", d0Stall, 0);
      applyNop();
      checkOutput("dup_fwd_a", d0FwdA, 2);
      checkOutput("dup_fwd_b", d0FwdB, 2);

      // Taken branch reading a load result: flush only on the issuing cycle.
      resetDut();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
      checkOutput("br_stall", d0Stall, 1);
      checkOutput("br_flush_held", d0IfFlush, 0);
      applyStimulus(1'b1, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
      checkOutput("br_flush_issue", d0IfFlush, 1);

      // Reset asserted in the middle of a two-cycle stall.
      resetDut();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      applyStimulus(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0);
      checkOutput("mid_stall_before", d1Stall, 1);
      checkOutput("mid_count_before", d1StallCount, 1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("mid_rst_stall", d1Stall, 0);
      checkOutput("mid_rst_count", d1StallCount, 0);
      checkOutput("mid_rst_pc_write", d1PcWrite, 1);
      resetDut();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
